// File: rtl/three_stage_pipeline_unloader_pkg.sv
// rtl/three_stage_pipeline_unloader_pkg.sv - shared unloader/loader encodings and widths
package three_stage_pipeline_unloader_pkg;

  localparam int BYTE_W   = 8;
  localparam int BYTE_CNT = 3;
  localparam int WORD_W   = BYTE_W * BYTE_CNT;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_B0   = 2'b01;
  localparam logic [1:0] ST_B1   = 2'b10;
  localparam logic [1:0] ST_B2   = 2'b11;

endpackage

// File: rtl/three_stage_pipeline_unloader_datapath.sv
// rtl/three_stage_pipeline_unloader_datapath.sv - word shift register presenting the low byte
module three_stage_pipeline_unloader_datapath
  import three_stage_pipeline_unloader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [BYTE_W-1:0] data_o
);

  logic [WORD_W-1:0] r_q, r_d;

  // Zero-fill shifting leaves R empty after the last byte, so idle shows 8'h00.
  always_comb begin
    r_d = r_q;
    if (load_i) begin
      r_d = data_i;
    end else if (shift_i) begin
      r_d = r_q >> BYTE_W;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign data_o = r_q[BYTE_W-1:0];

endmodule

// File: rtl/three_stage_pipeline_unloader.sv
// rtl/three_stage_pipeline_unloader.sv - serialises a 24-bit word into three bytes, LSB first
module three_stage_pipeline_unloader
  import three_stage_pipeline_unloader_pkg::*;
#(
  parameter logic [1:0] S_idle = ST_IDLE,
  parameter logic [1:0] S_b0   = ST_B0,
  parameter logic [1:0] S_b1   = ST_B1,
  parameter logic [1:0] S_b2   = ST_B2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Ld,
  input  logic [WORD_W-1:0] Data_in,
  input  logic              EN,
  input  logic              Rdy,
  output logic              Ld_ack,
  output logic              Valid,
  output logic [BYTE_W-1:0] Data_out,
  output logic              Done
);

  logic [1:0] state_q, state_d;
  logic       valid_q, ld_ack_q, ld_ack_d, done_q, done_d;
  logic       load, shift, xfer;

  assign xfer = valid_q && EN && Rdy;

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift    = 1'b0;
    ld_ack_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_idle: begin
        if (Ld) begin
          load     = 1'b1;
          ld_ack_d = 1'b1;
          state_d  = S_b0;
        end
      end
      S_b0: begin
        if (xfer) begin
          shift   = 1'b1;
          state_d = S_b1;
        end
      end
      S_b1: begin
        if (xfer) begin
          shift   = 1'b1;
          state_d = S_b2;
        end
      end
      default: begin
        // Final byte accepted: a waiting Ld refills without an idle bubble.
        if (xfer) begin
          done_d = 1'b1;
          if (Ld) begin
            load     = 1'b1;
            ld_ack_d = 1'b1;
            state_d  = S_b0;
          end else begin
            shift    = 1'b1;
            state_d  = S_idle;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_idle;
      valid_q  <= 1'b0;
      ld_ack_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= (state_d != S_idle);
      ld_ack_q <= ld_ack_d;
      done_q   <= done_d;
    end
  end

  three_stage_pipeline_unloader_datapath u_datapath (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (Data_in),
    .data_o  (Data_out)
  );

  assign Ld_ack = ld_ack_q;
  assign Valid  = valid_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_three_stage_pipeline_unloader.sv
// tb/tb_three_stage_pipeline_unloader.sv - directed self-checking bench for the byte unloader
module tb_three_stage_pipeline_unloader;

  logic        clk;
  logic        rst;
  logic        Ld;
  logic [23:0] Data_in;
  logic        EN;
  logic        Rdy;
  logic        Ld_ack;
  logic        Valid;
  logic [7:0]  Data_out;
  logic        Done;

  int checks;
  int errors;

  three_stage_pipeline_unloader dut (
    .clk      (clk),
    .rst      (rst),
    .Ld       (Ld),
    .Data_in  (Data_in),
    .EN       (EN),
    .Rdy      (Rdy),
    .Ld_ack   (Ld_ack),
    .Valid    (Valid),
    .Data_out (Data_out),
    .Done     (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector layout: {Valid, Ld_ack, Done, Data_out}
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; Ld = 1'b0; Data_in = 24'h0; EN = 1'b1; Rdy = 1'b1;
    step();
    step();
    checks++;
    if ({Valid, Ld_ack, Done, Data_out} !== {3'b000, 8'h00}) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", {Valid, Ld_ack, Done, Data_out}, {3'b000, 8'h00});
    end
    rst = 1'b1;
    step();
    checks++;
    if ({Valid, Ld_ack, Done, Data_out} !== {3'b000, 8'h00}) begin
      errors++;
      $display("FAIL reset_idle got %h exp %h", {Valid, Ld_ack, Done, Data_out}, {3'b000, 8'h00});
    end
  endtask

  task automatic test_basic();
    logic [10:0] exp [5];
    exp[0] = {3'b110, 8'hA1};
    exp[1] = {3'b100, 8'hB2};
    exp[2] = {3'b100, 8'hC3};
    exp[3] = {3'b001, 8'h00};
    exp[4] = {3'b000, 8'h00};
    EN = 1'b1; Rdy = 1'b1; Ld = 1'b1; Data_in = 24'hC3B2A1;
    for (int i = 0; i < 5; i++) begin
      step();
      Ld = 1'b0;
      checks++;
      if ({Valid, Ld_ack, Done, Data_out} !== exp[i]) begin
        errors++;
        $display("FAIL basic_seq[%0d] got %h exp %h", i, {Valid, Ld_ack, Done, Data_out}, exp[i]);
      end
    end
  endtask

  task automatic test_rdy_stall();
    EN = 1'b1; Rdy = 1'b1; Ld = 1'b1; Data_in = 24'hC3B2A1;
    step();
    Ld = 1'b0;
    step();
    checks++;
    if ({Valid, Ld_ack, Done, Data_out} !== {3'b100, 8'hB2}) begin
      errors++;
      $display("FAIL rdy_enter_b1 got %h exp %h", {Valid, Ld_ack, Done, Data_out}, {3'b100, 8'hB2});
    end
    Rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({Valid, Ld_ack, Done, Data_out} !== {3'b100, 8'hB2}) begin
        errors++;
        $display("FAIL rdy_hold[%0d] got %h exp %h", i, {Valid, Ld_ack, Done, Data_out}, {3'b100, 8'hB2});
      end
    end
    Rdy = 1'b1;
    step();
    checks++;
    if ({Valid, Ld_ack, Done, Data_out} !== {3'b100, 8'hC3}) begin
      errors++;
      $display("FAIL rdy_resume got %h exp %h", {Valid, Ld_ack, Done, Data_out}, {3'b100, 8'hC3});
    end
    step();
    checks++;
    if ({Valid, Ld_ack, Done, Data_out} !== {3'b001, 8'h00}) begin
      errors++;
      $display("FAIL rdy_done got %h exp %h", {Valid, Ld_ack, Done, Data_out}, {3'b001, 8'h00});
    end
    step();
  endtask

  task automatic test_en_stall();
    EN = 1'b0; Rdy = 1'b1; Ld = 1'b1; Data_in = 24'hC3B2A1;
    step();
    Ld = 1'b0;
    checks++;
    if ({Valid, Ld_ack, Done, Data_out} !== {3'b110, 8'hA1}) begin
      errors++;
      $display("FAIL en_load got %h exp %h", {Valid, Ld_ack, Done, Data_out}, {3'b110, 8'hA1});
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({Valid, Ld_ack, Done, Data_out} !== {3'b100, 8'hA1}) begin
        errors++;
        $display("FAIL en_hold[%0d] got %h exp %h", i, {Valid, Ld_ack, Done, Data_out}, {3'b100, 8'hA1});
      end
    end
    EN = 1'b1;
    step();
    checks++;
    if ({Valid, Ld_ack, Done, Data_out} !== {3'b100, 8'hB2}) begin
      errors++;
      $display("FAIL en_resume_b1 got %h exp %h", {Valid, Ld_ack, Done, Data_out}, {3'b100, 8'hB2});
    end
    step();
    checks++;
    if ({Valid, Ld_ack, Done, Data_out} !== {3'b100, 8'hC3}) begin
      errors++;
      $display("FAIL en_resume_b2 got %h exp %h", {Valid, Ld_ack, Done, Data_out}, {3'b100, 8'hC3});
    end
    step();
    checks++;
    if ({Valid, Ld_ack, Done, Data_out} !== {3'b001, 8'h00}) begin
      errors++;
      $display("FAIL en_done got %h exp %h", {Valid, Ld_ack, Done, Data_out}, {3'b001, 8'h00});
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp [4];
    exp[0] = {3'b111, 8'h44};
    exp[1] = {3'b100, 8'h55};
    exp[2] = {3'b100, 8'h66};
    exp[3] = {3'b001, 8'h00};
    EN = 1'b1; Rdy = 1'b1; Ld = 1'b1; Data_in = 24'hC3B2A1;
    step();
    Ld = 1'b0;
    step();
    step();
    checks++;
    if ({Valid, Ld_ack, Done, Data_out} !== {3'b100, 8'hC3}) begin
      errors++;
      $display("FAIL b2b_first_c3 got %h exp %h", {Valid, Ld_ack, Done, Data_out}, {3'b100, 8'hC3});
    end
    Ld = 1'b1; Data_in = 24'h665544;
    for (int i = 0; i < 4; i++) begin
      step();
      Ld = 1'b0;
      checks++;
      if ({Valid, Ld_ack, Done, Data_out} !== exp[i]) begin
        errors++;
        $display("FAIL b2b_seq[%0d] got %h exp %h", i, {Valid, Ld_ack, Done, Data_out}, exp[i]);
      end
    end
    step();
  endtask

  task automatic test_ld_ignored();
    EN = 1'b1; Rdy = 1'b1; Ld = 1'b1; Data_in = 24'hC3B2A1;
    step();
    Ld = 1'b0;
    step();
    Ld = 1'b1; Data_in = 24'hFFEEDD;
    step();
    Ld = 1'b0;
    checks++;
    if ({Valid, Ld_ack, Done, Data_out} !== {3'b100, 8'hC3}) begin
      errors++;
      $display("FAIL ldign_b2 got %h exp %h", {Valid, Ld_ack, Done, Data_out}, {3'b100, 8'hC3});
    end
    step();
    checks++;
    if ({Valid, Ld_ack, Done, Data_out} !== {3'b001, 8'h00}) begin
      errors++;
      $display("FAIL ldign_done got %h exp %h", {Valid, Ld_ack, Done, Data_out}, {3'b001, 8'h00});
    end
    step();
  endtask

  task automatic test_mid_reset();
    EN = 1'b1; Rdy = 1'b1; Ld = 1'b1; Data_in = 24'hC3B2A1;
    step();
    Ld = 1'b0;
    step();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({Valid, Ld_ack, Done, Data_out} !== {3'b000, 8'h00}) begin
      errors++;
      $display("FAIL midrst_async got %h exp %h", {Valid, Ld_ack, Done, Data_out}, {3'b000, 8'h00});
    end
    step();
    checks++;
    if ({Valid, Ld_ack, Done, Data_out} !== {3'b000, 8'h00}) begin
      errors++;
      $display("FAIL midrst_nodone got %h exp %h", {Valid, Ld_ack, Done, Data_out}, {3'b000, 8'h00});
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({Valid, Ld_ack, Done, Data_out} !== {3'b000, 8'h00}) begin
        errors++;
        $display("FAIL midrst_idle[%0d] got %h exp %h", i, {Valid, Ld_ack, Done, Data_out}, {3'b000, 8'h00});
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_rdy_stall();
    test_en_stall();
    test_back_to_back();
    test_ld_ignored();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/three_stage_pipeline_unloader.md
THREE_STAGE_PIPELINE_UNLOADER -- requirements
Module: three_stage_pipeline_unloader

Interface
REQ-001 SHALL have parameter S_idle, default 2'b00, meaning no word held.
REQ-002 SHALL have parameter S_b0, default 2'b01, meaning byte 0 (Data_in[7:0]) presented.
REQ-003 SHALL have parameter S_b1, default 2'b10, meaning byte 1 (Data_in[15:8]) presented.
REQ-004 SHALL have parameter S_b2, default 2'b11, meaning byte 2 (Data_in[23:16]) presented.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates occur on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset that is asynchronous and active-low.
REQ-007 SHALL have port Ld, input, 1, load request for Data_in.
REQ-008 SHALL have port Data_in, input, 24, parallel word {P2,P1,P0}.
REQ-009 SHALL have port EN, input, 1, transfer enable; low stalls output.
REQ-010 SHALL have port Rdy, input, 1, downstream ready.
REQ-011 SHALL have port Ld_ack, output, 1, one-cycle pulse on word capture.
REQ-012 SHALL have port Valid, output, 1, Data_out holds a live byte.
REQ-013 SHALL have port Data_out, output, 8, current byte.
REQ-014 SHALL have port Done, output, 1, one-cycle pulse after byte 2 accepted.

Function
REQ-015 SHALL hold a 24-bit shift register R and 2-bit state; all outputs registered.
REQ-016 SHALL define a transfer as the rising edge where Valid=1, EN=1 and Rdy=1.
REQ-017 SHALL, in S_idle with Ld=1, capture R<=Data_in, go to S_b0 and pulse Ld_ack; Ld=0 stays in S_idle.
REQ-018 SHALL make Valid=1 and Data_out=Data_in[7:0] on the first edge after capture (latency 1 cycle).
REQ-019 SHALL keep Valid=1 in S_b0, S_b1, S_b2 and Valid=0 in S_idle.
REQ-020 SHALL keep Data_out=R[7:0].
REQ-021 SHALL, on a transfer, shift R right by 8 (zero-fill) and step S_b0->S_b1->S_b2.
REQ-022 SHALL, when EN=0 or Rdy=0, hold state, R and Data_out unchanged (Valid stays 1).
REQ-023 SHALL ignore Ld in S_b0 and S_b1, and in S_b2 when no transfer occurs.
REQ-024 SHALL, on a transfer in S_b2, pulse Done next cycle.
REQ-025 SHALL, on that S_b2 transfer with Ld=1, recapture Data_in, pulse Ld_ack and go to S_b0 (back-to-back, no bubble).
REQ-026 SHALL, on that S_b2 transfer with Ld=0, go to S_idle with Valid=0.
REQ-027 SHALL drive Data_out=8'h00 in S_idle.
REQ-028 SHALL keep byte order LSB first, mirroring the loader's P0-first arrival.

Reset
REQ-029 SHALL, while rst=0, immediately force state=S_idle, R=0, Data_out=0, Valid=0, Ld_ack=0 and Done=0.
REQ-030 SHALL discard the word on a mid-transfer reset and produce no Done.
REQ-031 SHALL, after rst rises, need a fresh Ld in S_idle before any output.

Structure
REQ-032 SHALL put the state encodings, byte width 8 and byte count 3 in a shared package/include used with the loader.
REQ-033 SHALL split into the FSM (top) and one sub-module three_stage_pipeline_unloader_datapath holding R and Data_out.

Verification
REQ-034 SHALL cover: rst=0 mid-S_b1 -> Valid=0, Data_out=00 at once, and no Done.
REQ-035 SHALL cover: Ld with Data_in=24'hC3B2A1, EN=Rdy=1 -> Data_out A1,B2,C3 on consecutive cycles, then Done pulse, then Valid=0.
REQ-036 SHALL cover: Rdy=0 for 3 cycles in S_b1 -> Data_out holds B2, Valid=1, no Done.
REQ-037 SHALL cover: EN=0 in S_b0 -> state and A1 held; EN=1 resumes the sequence.
REQ-038 SHALL cover: Ld=1 with 24'h665544 during the S_b2 transfer -> Ld_ack, then 44 right after C3 with no Valid gap.
REQ-039 SHALL cover: Ld pulse in S_b1 -> ignored, no Ld_ack, and the sequence completes unchanged.
